// File: rtl/mem_ctrl.sv
// Arbitrates the single byte-wide RAM port between fetch and MEM, splitting each request into byte accesses.
// Reads complete N+2 cycles after accept, writes N+1; requesters hold req as a level until done (no other backpressure).
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_done_o,
  output logic [31:0]       if_inst_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_len_i,
  input  logic              mem_sext_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_done_o,
  output logic [31:0]       mem_rdata_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o,
  input  logic [7:0]        ram_din_i
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MEM_RD = 3'd1,
    S_MEM_WR = 3'd2,
    S_IF_RD  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        nb_q, nb_d;
  logic [2:0]        cyc_q, cyc_d;
  logic              is_if_q, is_if_d;
  logic              we_q, we_d;
  logic              sext_q, sext_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic              if_done, mem_done;
  logic [31:0]       load_word;
  logic [31:0]       wshift;

  always_comb begin
    load_word = buf_q;
    if (nb_q == 3'd1) begin
      load_word = {{24{sext_q & buf_q[7]}}, buf_q[7:0]};
    end else if (nb_q == 3'd2) begin
      load_word = {{16{sext_q & buf_q[15]}}, buf_q[15:0]};
    end
  end

  // A flush landing in the IF done cycle must still suppress the pulse, so done is combinational.
  assign if_done  = (state_q == S_DONE) && is_if_q && !if_flush_i;
  assign mem_done = (state_q == S_DONE) && !is_if_q;
  assign wshift   = wdata_q >> {cyc_q, 3'b000};

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    nb_d        = nb_q;
    cyc_d       = cyc_q;
    is_if_d     = is_if_q;
    we_d        = we_q;
    sext_d      = sext_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_req_i) begin
          base_d  = mem_addr_i;
          is_if_d = 1'b0;
          we_d    = mem_we_i;
          sext_d  = mem_sext_i;
          wdata_d = mem_wdata_i;
          cyc_d   = 3'd1;
          buf_d   = 32'd0;
          ram_a_d = mem_addr_i;
          case (mem_len_i)
            2'b00:   nb_d = 3'd1;
            2'b01:   nb_d = 3'd2;
            default: nb_d = 3'd4;
          endcase
          if (mem_we_i) begin
            ram_wr_d   = 1'b1;
            ram_dout_d = mem_wdata_i[7:0];
            state_d    = S_MEM_WR;
          end else begin
            state_d = S_MEM_RD;
          end
        end else if (if_req_i && !if_flush_i) begin
          base_d  = if_addr_i;
          is_if_d = 1'b1;
          we_d    = 1'b0;
          sext_d  = 1'b0;
          nb_d    = 3'd4;
          cyc_d   = 3'd1;
          buf_d   = 32'd0;
          ram_a_d = if_addr_i;
          state_d = S_IF_RD;
        end
      end

      S_MEM_RD, S_IF_RD: begin
        if (state_q == S_IF_RD && if_flush_i) begin
          state_d = S_IDLE;
        end else begin
          cyc_d = cyc_q + 3'd1;
          if (cyc_q < nb_q) begin
            ram_a_d = base_q + ADDR_W'(cyc_q);
          end
          // RAM answers one cycle late, so cycle j carries byte j-2.
          for (int i = 0; i < 4; i++) begin
            if (cyc_q == 3'(i + 2)) begin
              buf_d[8*i +: 8] = ram_din_i;
            end
          end
          if (cyc_q == nb_q + 3'd1) begin
            state_d = S_DONE;
          end
        end
      end

      S_MEM_WR: begin
        if (cyc_q < nb_q) begin
          ram_a_d    = base_q + ADDR_W'(cyc_q);
          ram_dout_d = wshift[7:0];
          ram_wr_d   = 1'b1;
          cyc_d      = cyc_q + 3'd1;
        end else begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        if (if_done) begin
          if_inst_d = buf_q;
        end
        if (mem_done && !we_q) begin
          mem_rdata_d = load_word;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      nb_q        <= 3'd0;
      cyc_q       <= 3'd0;
      is_if_q     <= 1'b0;
      we_q        <= 1'b0;
      sext_q      <= 1'b0;
      wdata_q     <= 32'd0;
      buf_q       <= 32'd0;
      if_inst_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
      ram_a_q     <= '0;
      ram_dout_q  <= 8'd0;
      ram_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      nb_q        <= nb_d;
      cyc_q       <= cyc_d;
      is_if_q     <= is_if_d;
      we_q        <= we_d;
      sext_q      <= sext_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
    end
  end

  assign if_done_o   = if_done;
  assign mem_done_o  = mem_done;
  assign if_inst_o   = if_done ? buf_q : if_inst_q;
  assign mem_rdata_o = (mem_done && !we_q) ? load_word : mem_rdata_q;
  assign busy_o      = (state_q != S_IDLE);
  assign ram_a_o     = ram_a_q;
  assign ram_dout_o  = ram_dout_q;
  assign ram_wr_o    = ram_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: RAM model with one-cycle read latency, directed scenarios plus randomized transactions.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, if_flush_i, if_done_o;
  logic [31:0] if_addr_i, if_inst_o;
  logic        mem_req_i, mem_we_i, mem_sext_i, mem_done_o;
  logic [1:0]  mem_len_i;
  logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
  logic        busy_o, ram_wr_o;
  logic [31:0] ram_a_o;
  logic [7:0]  ram_dout_o;
  logic [7:0]  ram_din_i = 8'd0;

  logic [7:0]  mem [0:4095];
  int          n_checks = 0;
  int          n_errs = 0;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_done_o(if_done_o), .if_inst_o(if_inst_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i),
    .mem_sext_i(mem_sext_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o), .busy_o(busy_o),
    .ram_a_o(ram_a_o), .ram_dout_o(ram_dout_o), .ram_wr_o(ram_wr_o),
    .ram_din_i(ram_din_i)
  );

  always #5 clk = ~clk;

  // External RAM: 4 KiB image aliased across the address space, read data one cycle late.
  always @(posedge clk) begin
    ram_din_i <= mem[ram_a_o[11:0]];
    if (ram_wr_o) mem[ram_a_o[11:0]] = ram_dout_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] w);
    logic [31:0] p;
    for (int k = 0; k < 4; k++) begin
      p = a + 32'(k);
      mem[p[11:0]] = w[8*k +: 8];
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_wr"}, 32'(ram_wr_o), 32'd0);
    check({tag, "_addr"}, ram_a_o, 32'd0);
    check({tag, "_dout"}, 32'(ram_dout_o), 32'd0);
    check({tag, "_dones"}, {30'd0, if_done_o, mem_done_o}, 32'd0);
    check({tag, "_inst"}, if_inst_o, 32'd0);
    check({tag, "_rdata"}, mem_rdata_o, 32'd0);
  endtask

  // One complete transaction, checked against values derived from the RAM image and the byte/extension rules.
  task automatic run_txn(input bit is_if, input bit we, input logic [1:0] len, input bit sext,
                         input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    int          n, cyc;
    bit          seen, wrong_done;
    logic [31:0] exp, got, a;
    logic [31:0] wa_q[$];
    logic [7:0]  wb_q[$];
    n = is_if ? 4 : (len == 2'd0 ? 1 : (len == 2'd1 ? 2 : 4));
    exp = 32'd0;
    for (int k = 0; k < n; k++) begin
      a = addr + 32'(k);
      exp = exp | (32'(mem[a[11:0]]) << (8 * k));
    end
    if (!is_if && sext && n < 4 && exp[8*n-1]) exp = exp | ~((32'd1 << (8 * n)) - 32'd1);
    if (is_if) begin
      if_req_i = 1'b1; if_addr_i = addr;
    end else begin
      mem_req_i = 1'b1; mem_we_i = we; mem_len_i = len; mem_sext_i = sext;
      mem_addr_i = addr; mem_wdata_i = wdata;
    end
    seen = 1'b0; wrong_done = 1'b0; cyc = 0; got = 32'd0;
    while (!seen && cyc < 20) begin
      tick();
      cyc++;
      if (ram_wr_o) begin
        wa_q.push_back(ram_a_o);
        wb_q.push_back(ram_dout_o);
      end
      if (is_if ? mem_done_o : if_done_o) wrong_done = 1'b1;
      if (is_if ? if_done_o : mem_done_o) begin
        seen = 1'b1;
        got = is_if ? if_inst_o : mem_rdata_o;
      end
    end
    if_req_i = 1'b0; mem_req_i = 1'b0;
    check({tag, "_done"}, 32'(seen), 32'd1);
    check({tag, "_other_done"}, 32'(wrong_done), 32'd0);
    check({tag, "_latency"}, 32'(cyc), 32'(we ? n + 1 : n + 2));
    if (we) begin
      check({tag, "_nwrites"}, 32'(wa_q.size()), 32'(n));
      for (int k = 0; k < n && k < wa_q.size(); k++) begin
        check({tag, "_waddr"}, wa_q[k], addr + 32'(k));
        check({tag, "_wbyte"}, 32'(wb_q[k]), (wdata >> (8 * k)) & 32'hFF);
      end
    end else begin
      check({tag, "_nwrites"}, 32'(wa_q.size()), 32'd0);
      check({tag, "_data"}, got, exp);
    end
    tick();
    check({tag, "_idle"}, 32'(busy_o), 32'd0);
    if (!we) check({tag, "_hold"}, is_if ? if_inst_o : mem_rdata_o, exp);
  endtask

  initial begin
    int          cyc, ndone;
    bit          seen;
    logic [31:0] inst_before, r;
    rst = 1'b1;
    if_req_i = 0; if_addr_i = 0; if_flush_i = 0;
    mem_req_i = 0; mem_we_i = 0; mem_len_i = 0; mem_sext_i = 0; mem_addr_i = 0; mem_wdata_i = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    poke(32'h100, 32'h00000013);
    run_txn(1, 0, 2'd2, 0, 32'h100, 0, "if_word");

    // Simultaneous requests: MEM goes first, IF is taken in the IDLE cycle after MEM's done.
    poke(32'h200, 32'hDEADBEEF);
    poke(32'h300, 32'h00A00093);
    if_req_i = 1; if_addr_i = 32'h300;
    mem_req_i = 1; mem_we_i = 0; mem_len_i = 2'd2; mem_sext_i = 0; mem_addr_i = 32'h200;
    seen = 0; cyc = 0; ndone = 0;
    while (!seen && cyc < 20) begin
      tick(); cyc++;
      if (if_done_o) ndone++;
      if (mem_done_o) begin seen = 1; r = mem_rdata_o; end
    end
    mem_req_i = 0;
    check("arb_mem_done", 32'(seen), 32'd1);
    check("arb_mem_lat", 32'(cyc), 32'd6);
    check("arb_mem_data", r, 32'hDEADBEEF);
    check("arb_if_early", 32'(ndone), 32'd0);
    seen = 0; cyc = 0;
    while (!seen && cyc < 20) begin
      tick(); cyc++;
      if (if_done_o) begin seen = 1; r = if_inst_o; end
    end
    if_req_i = 0;
    check("arb_if_done", 32'(seen), 32'd1);
    check("arb_if_lat", 32'(cyc), 32'd7);
    check("arb_if_data", r, 32'h00A00093);
    tick();

    mem[12'h010] = 8'h80;
    run_txn(0, 0, 2'd0, 1, 32'h10, 0, "lb");
    run_txn(0, 0, 2'd0, 0, 32'h10, 0, "lbu");
    poke(32'h020, 32'h00008001);
    run_txn(0, 0, 2'd1, 1, 32'h20, 0, "lh");
    run_txn(0, 1, 2'd2, 0, 32'h3FE, 32'h11223344, "sw");
    run_txn(0, 0, 2'd2, 0, 32'h3FE, 0, "sw_readback");
    run_txn(0, 1, 2'd1, 0, 32'hFFFFFFFF, 32'h0000A55A, "sh_wrap");

    // Flush on the third IF_RD cycle.
    inst_before = if_inst_o;
    if_req_i = 1; if_addr_i = 32'h100;
    tick(); tick(); tick();
    if_flush_i = 1; if_req_i = 0;
    tick();
    if_flush_i = 0;
    check("flush_idle", 32'(busy_o), 32'd0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (if_done_o) ndone++;
      tick();
    end
    check("flush_no_done", 32'(ndone), 32'd0);
    check("flush_inst_kept", if_inst_o, inst_before);
    run_txn(1, 0, 2'd2, 0, 32'h300, 0, "after_flush");

    // Flush arriving in the IF done cycle itself.
    inst_before = if_inst_o;
    if_req_i = 1; if_addr_i = 32'h100;
    for (int i = 0; i < 6; i++) tick();
    if_flush_i = 1; if_req_i = 0;
    #1;
    check("dflush_no_done", 32'(if_done_o), 32'd0);
    check("dflush_inst_kept", if_inst_o, inst_before);
    tick();
    if_flush_i = 0;
    check("dflush_idle", 32'(busy_o), 32'd0);
    tick();
    check("dflush_inst_after", if_inst_o, inst_before);

    // Reset part-way through a word store.
    mem_req_i = 1; mem_we_i = 1; mem_len_i = 2'd2; mem_addr_i = 32'h500; mem_wdata_i = 32'hCAFEF00D;
    tick(); tick();
    rst = 1; mem_req_i = 0;
    tick();
    check_reset_outputs("midrst");
    rst = 0;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (if_done_o || mem_done_o || busy_o) ndone++;
    end
    check("midrst_quiet", 32'(ndone), 32'd0);
    run_txn(0, 1, 2'd2, 0, 32'h500, 32'h01020304, "post_rst_sw");
    run_txn(0, 0, 2'd2, 0, 32'h500, 0, "post_rst_lw");

    for (int t = 0; t < 60; t++) begin
      logic [31:0] ra;
      bit          rif;
      ra = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3)))
                                        : 32'($urandom_range(0, 4095));
      rif = ($urandom_range(0, 3) == 0);
      run_txn(rif, rif ? 1'b0 : 1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
